// File: rtl/bitbang_pkg.sv
// Shared definitions for the bitbang configuration transmitter: trailer
// patterns, command encoding and the FSM/phase enumerations.
package bitbang_pkg;

    localparam logic [15:0] ON_PATTERN  = 16'hFAB1;
    localparam logic [15:0] OFF_PATTERN = 16'hFAB0;

    localparam logic CMD_DATA = 1'b0;
    localparam logic CMD_STOP = 1'b1;

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;
    typedef enum logic [1:0] {PH_D, PH_R, PH_C, PH_F} phase_t;

    // Control bits 31..16 are always zero; the trailer occupies bits 15..0.
    function automatic logic ctrl_bit(input logic [15:0] trailer, input logic [4:0] idx);
        return idx[4] ? 1'b0 : trailer[idx[3:0]];
    endfunction

endpackage

// File: rtl/bitbang_tx_phase_gen.sv
// Phase timer for bitbang_tx: PHASE_CYCLES clocks per phase, four phases
// (D, R, C, F) per bit, with a bit_done pulse on the last cycle of F.
module bitbang_tx_phase_gen
    import bitbang_pkg::*;
#(
    parameter int PHASE_CYCLES = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   start,
    input  logic   run,
    output phase_t phase,
    output logic   phase_last,
    output logic   bit_done
);

    localparam int CNT_W = $clog2(PHASE_CYCLES);

    logic [CNT_W-1:0] cnt;

    assign phase_last = (cnt == CNT_W'(PHASE_CYCLES - 1));
    assign bit_done   = run && phase_last && (phase == PH_F);

    always_ff @(posedge clk) begin
        if (reset || start) begin
            cnt   <= '0;
            phase <= PH_D;
        end else if (run) begin
            if (phase_last) begin
                cnt   <= '0;
                phase <= phase_t'(phase + 2'd1);
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bitbang_tx.sv
// Bitbang configuration transmitter: one 32-bit data/control frame per word.
// Optional one-entry holding register enabled by BITBANG_TX_SKID_EN.
module bitbang_tx
    import bitbang_pkg::*;
#(
    parameter int PHASE_CYCLES = 4,
    parameter int GAP_CYCLES   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] tx_data,
    input  logic        tx_cmd,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        s_clk,
    output logic        s_data,
    output logic        busy
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    state_t           state;
    logic [31:0]      data_q;
    logic [15:0]      trailer_q;
    logic [4:0]       bit_idx;
    logic [4:0]       bit_idx_dec;
    logic [GAP_W-1:0] gap_cnt;

    phase_t      phase;
    logic        phase_last;
    logic        bit_done;
    logic        accept;
    logic        gap_end;
    logic        launch;
    logic        launch_cmd;
    logic        ready_next;
    logic [31:0] launch_data;
    logic [31:0] launch_word;

    assign accept      = tx_valid && tx_ready;
    assign gap_end     = (state == ST_GAP) && (gap_cnt == '0);
    assign bit_idx_dec = bit_idx - 5'd1;

`ifdef BITBANG_TX_SKID_EN
    logic        hold_valid;
    logic [31:0] hold_data;
    logic        hold_cmd;
    logic        launch_hold;
    logic        launch_tx;
    logic        fill_hold;

    // A word arriving on the last GAP cycle with the holder empty bypasses it.
    assign launch_hold = gap_end && hold_valid;
    assign launch_tx   = accept && ((state == ST_IDLE) || (gap_end && !hold_valid));
    assign fill_hold   = accept && !launch_tx;
    assign launch      = launch_hold || launch_tx;
    assign launch_data = launch_hold ? hold_data : tx_data;
    assign launch_cmd  = launch_hold ? hold_cmd  : tx_cmd;
    assign ready_next  = !(fill_hold || (hold_valid && !launch_hold));

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid <= 1'b0;
        end else if (fill_hold) begin
            hold_valid <= 1'b1;
            hold_data  <= tx_data;
            hold_cmd   <= tx_cmd;
        end else if (launch_hold) begin
            hold_valid <= 1'b0;
        end
    end
`else
    assign launch      = accept;
    assign launch_data = tx_data;
    assign launch_cmd  = tx_cmd;
    assign ready_next  = ((state == ST_IDLE) && !accept) || gap_end;
`endif

    assign launch_word = (launch_cmd == CMD_STOP) ? 32'd0 : launch_data;

    bitbang_tx_phase_gen #(
        .PHASE_CYCLES(PHASE_CYCLES)
    ) u_phase_gen (
        .clk       (clk),
        .reset     (reset),
        .start     (launch),
        .run       (state == ST_SHIFT),
        .phase     (phase),
        .phase_last(phase_last),
        .bit_done  (bit_done)
    );

    // NOTE: data_q, trailer_q, bit_idx and gap_cnt are left out of reset on
    // purpose; they are always loaded before being used.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            s_clk    <= 1'b0;
            s_data   <= 1'b0;
            busy     <= 1'b0;
            tx_ready <= 1'b0;
        end else begin
            tx_ready <= ready_next;
            if (launch) begin
                state     <= ST_SHIFT;
                busy      <= 1'b1;
                s_clk     <= 1'b0;
                s_data    <= launch_word[31];
                data_q    <= launch_word;
                trailer_q <= (launch_cmd == CMD_STOP) ? OFF_PATTERN : ON_PATTERN;
                bit_idx   <= 5'd31;
            end else begin
                case (state)
                    ST_IDLE: begin
                        s_clk  <= 1'b0;
                        s_data <= 1'b0;
                        busy   <= 1'b0;
                    end
                    ST_SHIFT: begin
                        if (bit_done) begin
                            if (bit_idx == 5'd0) begin
                                state   <= ST_GAP;
                                s_data  <= 1'b0;
                                gap_cnt <= GAP_W'(GAP_CYCLES - 1);
                            end else begin
                                bit_idx <= bit_idx_dec;
                                s_data  <= data_q[bit_idx_dec];
                            end
                        end else if (phase_last) begin
                            // Outputs are registered, so each case sets up the next phase.
                            case (phase)
                                PH_D:    s_clk  <= 1'b1;
                                PH_R:    s_data <= ctrl_bit(trailer_q, bit_idx);
                                PH_C:    s_clk  <= 1'b0;
                                default: ;
                            endcase
                        end
                    end
                    ST_GAP: begin
                        if (gap_cnt == '0) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            gap_cnt <= gap_cnt - 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bitbang_tx.sv
// Self-checking bench for bitbang_tx: receiver model on s_clk/s_data, frame
// timing checks and randomized words; covers BITBANG_TX_SKID_EN when defined.
module tb_bitbang_tx;
    import bitbang_pkg::*;

    localparam int PC     = 2;
    localparam int GAP    = 8;
    localparam int BUDGET = 4000;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic [31:0] tx_data  = 32'd0;
    logic        tx_cmd   = 1'b0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic        s_clk;
    logic        s_data;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    bitbang_tx #(
        .PHASE_CYCLES(PC),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .tx_data (tx_data),
        .tx_cmd  (tx_cmd),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .s_clk   (s_clk),
        .s_data  (s_data),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Receiver model and line monitor, sampled on the falling clk edge.
    logic        prev_clk  = 1'b0;
    logic        prev_data = 1'b0;
    logic        prev_busy = 1'b0;
    logic        m_rise, m_fall, m_chg;
    int          rise_cnt = 0, fall_cnt = 0, busy_cycles = 0, busy_falls = 0, ready_busy = 0;
    int          low_run = 0, last_rise_low = 0, end_low = 0;
    int          data_age = 1000, edge_age = 1000;
    logic [31:0] rise_bits  = 32'd0;
    logic [15:0] ctrl_hist  = 16'd0;
    logic [31:0] rx_data    = 32'd0;
    int          rx_strobes = 0;
    logic        rx_active  = 1'b0;
    logic [31:0] strobe_q[$];

    always @(negedge clk) begin
        m_rise   = s_clk && !prev_clk;
        m_fall   = !s_clk && prev_clk;
        m_chg    = (s_data !== prev_data);
        data_age = m_chg ? 1 : ((data_age < 1000) ? data_age + 1 : 1000);
        edge_age = (m_rise || m_fall) ? 0 : ((edge_age < 1000) ? edge_age + 1 : 1000);
        if (reset) begin
            data_age = 1000;
            edge_age = 1000;
        end else begin
            if (m_rise || m_fall) check("setup_before_edge", 32'(data_age > PC), 32'd1);
            if (m_chg)            check("hold_after_edge", 32'(edge_age >= PC), 32'd1);
        end
        if (m_rise) begin
            rise_cnt++;
            rise_bits     = {rise_bits[30:0], s_data};
            last_rise_low = low_run;
        end
        if (m_fall) begin
            fall_cnt++;
            ctrl_hist = {ctrl_hist[14:0], s_data};
            if (ctrl_hist == ON_PATTERN) begin
                rx_data   = rise_bits;
                rx_active = 1'b1;
                rx_strobes++;
                strobe_q.push_back(rise_bits);
            end else if (ctrl_hist == OFF_PATTERN) begin
                rx_active = 1'b0;
            end
        end
        if (busy) busy_cycles++;
        if (busy && tx_ready) ready_busy++;
        if (prev_busy && !busy) begin
            busy_falls++;
            end_low = low_run;
        end
        low_run   = s_clk ? 0 : low_run + 1;
        prev_clk  = s_clk;
        prev_data = s_data;
        prev_busy = busy;
    end

    // Expected receiver state, derived from the frame rules.
    logic [31:0] exp_data    = 32'd0;
    int          exp_strobes = 0;
    logic        exp_active  = 1'b0;

    function automatic void model_apply(input logic [31:0] w, input logic c);
        if (c == CMD_DATA) begin
            exp_data   = w;
            exp_active = 1'b1;
            exp_strobes++;
        end else begin
            exp_active = 1'b0;
        end
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w, input logic c, input bit scramble,
                        output logic busy_at_accept);
        int n = 0;
        tick();
        tx_data  = w;
        tx_cmd   = c;
        tx_valid = 1'b1;
        while (!tx_ready && n < BUDGET) begin
            if (scramble) tx_data = $urandom;
            tick();
            n++;
        end
        tx_data = w;
        check("accept_timeout", 32'(tx_ready), 32'd1);
        busy_at_accept = busy;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_data  = $urandom;
        tx_cmd   = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < BUDGET) begin
            tick();
            n++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic wait_rises(input int target);
        int n = 0;
        while (rise_cnt < target && n < BUDGET) begin
            tick();
            n++;
        end
        check("rise_timeout", 32'(rise_cnt >= target), 32'd1);
    endtask

    task automatic run_frame(input logic [31:0] w, input logic c, input bit probe_first);
        int   r0, f0, b0;
        logic ba;
        r0 = rise_cnt;
        f0 = fall_cnt;
        b0 = busy_cycles;
        send(w, c, 1'b0, ba);
        if (probe_first) begin
            tick();
            check("first_bit_s_data", 32'(s_data), 32'((c == CMD_STOP) ? 1'b0 : w[31]));
            check("first_bit_s_clk", 32'(s_clk), 32'd0);
            check("first_bit_busy", 32'(busy), 32'd1);
        end
        wait_idle();
        model_apply(w, c);
        check("rise_edges", 32'(rise_cnt - r0), 32'd32);
        check("fall_edges", 32'(fall_cnt - f0), 32'd32);
        check("data_bits", rise_bits, (c == CMD_STOP) ? 32'd0 : w);
        check("busy_cycles", 32'(busy_cycles - b0), 32'(128 * PC + GAP));
        check("tail_low_cycles", 32'(end_low), 32'(PC + GAP));
        check("rx_data", rx_data, exp_data);
        check("rx_strobes", 32'(rx_strobes), 32'(exp_strobes));
        check("rx_active", 32'(rx_active), 32'(exp_active));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          r0, bf0, rb0;
        logic        ba;
        logic [31:0] w;

        // NOTE: bench drives DUT inputs with blocking assignments away from posedge.
        repeat (3) tick();
        check("reset_tx_ready", 32'(tx_ready), 32'd0);
        check("reset_s_clk", 32'(s_clk), 32'd0);
        check("reset_s_data", 32'(s_data), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick();
        check("post_reset_tx_ready", 32'(tx_ready), 32'd1);

        run_frame(32'hDEADBEEF, CMD_DATA, 1'b1);
        run_frame(32'hFFFFFFFF, CMD_STOP, 1'b0);

        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 4)) tick();
            run_frame($urandom, ($urandom_range(0, 3) == 0) ? CMD_STOP : CMD_DATA, 1'b0);
        end

`ifdef BITBANG_TX_SKID_EN
        r0  = rise_cnt;
        bf0 = busy_falls;
        send(32'h00000001, CMD_DATA, 1'b0, ba);
        send(32'h80000000, CMD_DATA, 1'b0, ba);
        check("skid_accept_while_busy", 32'(ba), 32'd1);
        model_apply(32'h00000001, CMD_DATA);
        model_apply(32'h80000000, CMD_DATA);
        wait_rises(r0 + 33);
        check("skid_frame_gap", 32'(last_rise_low), 32'(2 * PC + GAP));
        wait_idle();
        check("skid_busy_falls", 32'(busy_falls - bf0), 32'd1);
        check("skid_strobe_first", strobe_q[strobe_q.size() - 2], 32'h00000001);
        check("skid_strobe_second", strobe_q[strobe_q.size() - 1], 32'h80000000);
        check("skid_rx_strobes", 32'(rx_strobes), 32'(exp_strobes));
`else
        r0  = rise_cnt;
        rb0 = ready_busy;
        w   = $urandom;
        send(32'h12345678, CMD_DATA, 1'b0, ba);
        send(w, CMD_DATA, 1'b1, ba);
        check("holdoff_accept_idle", 32'(ba), 32'd0);
        model_apply(32'h12345678, CMD_DATA);
        model_apply(w, CMD_DATA);
        wait_rises(r0 + 33);
        check("holdoff_frame_gap", 32'(last_rise_low), 32'(2 * PC + GAP + 1));
        wait_idle();
        check("holdoff_ready_low", 32'(ready_busy - rb0), 32'd0);
        check("holdoff_strobe_first", strobe_q[strobe_q.size() - 2], 32'h12345678);
        check("holdoff_strobe_second", strobe_q[strobe_q.size() - 1], w);
        check("holdoff_rx_strobes", 32'(rx_strobes), 32'(exp_strobes));
`endif

        // Reset while bit 20 is on the line: no trailer, so no receiver update.
        r0 = rise_cnt;
        send($urandom | 32'h1, CMD_DATA, 1'b0, ba);
        wait_rises(r0 + 12);
        reset = 1'b1;
        tick();
        check("midreset_s_clk", 32'(s_clk), 32'd0);
        check("midreset_s_data", 32'(s_data), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_tx_ready", 32'(tx_ready), 32'd0);
        reset = 1'b0;
        tick();
        check("midreset_ready_after", 32'(tx_ready), 32'd1);
        repeat (4 * PC) tick();
        check("midreset_rx_strobes", 32'(rx_strobes), 32'(exp_strobes));
        check("midreset_rx_data", rx_data, exp_data);
        check("midreset_rx_active", 32'(rx_active), 32'(exp_active));

        run_frame($urandom, CMD_DATA, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
